// File: rtl/counter_mod_nb.sv
// counter_mod_nb: parametrised modulo-MOD up/down counter with synchronous
// saturating load, count enable, ripple carry for cascading and an optional
// one-shot halt (ONESHOT=1).
// Optional feature macro: COUNTER_OVF_STICKY_EN -- when defined, ovf is a
// sticky flag set on every wrap and cleared by load or rst; when undefined,
// ovf is tied to 0 and no flop is generated.
module counter_mod_nb #(
    parameter int WIDTH   = 4,
    parameter int MOD     = 16,
    parameter int ONESHOT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic             rc,
    output logic             tc,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] TERM_UP    = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL    = WIDTH'(1);
    localparam bit               ONESHOT_EN = (ONESHOT != 0);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] load_val_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic             tc_s;
    logic             halted_s;

    // Terminal-count detect against the current direction, halt decode and load saturation.
    always_comb begin
        halted_s   = (state_r == ST_HALT);
        tc_s       = 1'b0;
        load_val_s = d_in;
        if (up) begin
            tc_s = (q_r == TERM_UP);
        end else begin
            tc_s = (q_r == ZERO_VAL);
        end
        if (d_in > TERM_UP) begin
            load_val_s = TERM_UP;
        end else begin
            load_val_s = d_in;
        end
    end

    // Next count: load beats count; compare before stepping so nothing carries past WIDTH.
    always_comb begin
        q_nxt_s = q_r;
        if (load) begin
            q_nxt_s = load_val_s;
        end else if (ce && !halted_s) begin
            if (tc_s) begin
                if (ONESHOT_EN) begin
                    q_nxt_s = q_r;
                end else if (up) begin
                    q_nxt_s = ZERO_VAL;
                end else begin
                    q_nxt_s = TERM_UP;
                end
            end else if (up) begin
                q_nxt_s = q_r + ONE_VAL;
            end else begin
                q_nxt_s = q_r - ONE_VAL;
            end
        end else begin
            q_nxt_s = q_r;
        end
    end

    // One-shot RUN/HALT next state; stays in RUN when the one-shot mode is off.
    always_comb begin
        state_nxt_s = state_r;
        if (!ONESHOT_EN) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load) begin
                        state_nxt_s = ST_RUN;
                    end else if (ce && tc_s) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (load) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HALT;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // Count and one-shot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r     <= ZERO_VAL;
            state_r <= ST_RUN;
        end else begin
            q_r     <= q_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    assign q    = q_r;
    assign tc   = tc_s;
    assign rc   = ce & tc_s & ~halted_s;
    assign done = halted_s;

`ifdef COUNTER_OVF_STICKY_EN
    logic ovf_r;
    logic wrap_s;

    assign wrap_s = ce & tc_s & ~halted_s & ~load;

    // Sticky wrap flag: set on any wrap edge, cleared only by load or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (load) begin
            ovf_r <= 1'b0;
        end else if (wrap_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_counter_mod_nb.sv
// tb_counter_mod_nb: directed plus randomized checks of counter_mod_nb
// (WIDTH=4, MOD=10) against an arithmetic reference model, a one-shot
// instance and a two-stage decade cascade.
module tb_counter_mod_nb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // main instance (wrapping)
    logic       ce0, up0, load0;
    logic [3:0] d0, q0;
    logic       rc0, tc0, done0, ovf0;
    // one-shot instance
    logic       ce1, up1, load1;
    logic [3:0] d1, q1;
    logic       rc1, tc1, done1, ovf1;
    // cascade
    logic       cce;
    logic [3:0] qlo, qhi;
    logic       rclo, tclo, donelo, ovflo, rchi, tchi, donehi, ovfhi;

    int n_checks = 0;
    int n_errors = 0;
    int mq;
    bit mov;

    counter_mod_nb #(.WIDTH(4), .MOD(10), .ONESHOT(0)) u0 (
        .clk(clk), .rst(rst), .ce(ce0), .up(up0), .load(load0), .d_in(d0),
        .q(q0), .rc(rc0), .tc(tc0), .done(done0), .ovf(ovf0));

    counter_mod_nb #(.WIDTH(4), .MOD(10), .ONESHOT(1)) u1 (
        .clk(clk), .rst(rst), .ce(ce1), .up(up1), .load(load1), .d_in(d1),
        .q(q1), .rc(rc1), .tc(tc1), .done(done1), .ovf(ovf1));

    counter_mod_nb #(.WIDTH(4), .MOD(10), .ONESHOT(0)) u_lo (
        .clk(clk), .rst(rst), .ce(cce), .up(1'b1), .load(1'b0), .d_in(4'd0),
        .q(qlo), .rc(rclo), .tc(tclo), .done(donelo), .ovf(ovflo));

    counter_mod_nb #(.WIDTH(4), .MOD(10), .ONESHOT(0)) u_hi (
        .clk(clk), .rst(rst), .ce(rclo), .up(1'b1), .load(1'b0), .d_in(4'd0),
        .q(qhi), .rc(rchi), .tc(tchi), .done(donehi), .ovf(ovfhi));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ovf(input bit m);
`ifdef COUNTER_OVF_STICKY_EN
        return m;
`else
        return 1'b0 & m;
`endif
    endfunction

    function automatic bit model_tc();
        return up0 ? (mq == 9) : (mq == 0);
    endfunction

    // One clock edge of the main instance; the model steps by modular arithmetic.
    task automatic edge_only();
        @(posedge clk);
        if (load0) begin
            mq  = (int'(d0) > 9) ? 9 : int'(d0);
            mov = 1'b0;
        end else if (ce0) begin
            if (up0) begin
                if (mq == 9) mov = 1'b1;
                mq = (mq + 1) % 10;
            end else begin
                if (mq == 0) mov = 1'b1;
                mq = (mq + 9) % 10;
            end
        end
        #1;
        check("q", 32'(q0), 32'(mq));
        check("done", 32'(done0), 32'd0);
        check("ovf", 32'(ovf0), 32'(exp_ovf(mov)));
    endtask

    task automatic edge_u0();
        #1;
        check("tc", 32'(tc0), 32'(model_tc()));
        check("rc", 32'(rc0), 32'(ce0 & model_tc()));
        edge_only();
    endtask

    initial begin
        rst = 1'b1;
        ce0 = 1'b0; up0 = 1'b1; load0 = 1'b0; d0 = 4'd0;
        ce1 = 1'b0; up1 = 1'b1; load1 = 1'b0; d1 = 4'd0;
        cce = 1'b0;
        mq = 0; mov = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_q", 32'(q0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_tc", 32'(tc0), 32'd0);
        check("rst_q1", 32'(q1), 32'd0);
        check("rst_casc", 32'({qhi, qlo}), 32'd0);

        // count up 12 cycles from 0: wraps after 9
        ce0 = 1'b1; up0 = 1'b1;
        for (int i = 0; i < 12; i++) edge_u0();

        // load 1, count down through 0 with a direction toggle at 0
        ce0 = 1'b0; load0 = 1'b1; d0 = 4'd1;
        edge_u0();
        load0 = 1'b0; ce0 = 1'b1; up0 = 1'b0;
        edge_u0();
        ce0 = 1'b0;
        edge_u0();
        up0 = 1'b1;
        edge_u0();
        up0 = 1'b0; ce0 = 1'b1;
        edge_u0();
        edge_u0();

        // saturating load with ce asserted
        load0 = 1'b1; d0 = 4'd13; ce0 = 1'b1; up0 = 1'b1;
        edge_u0();
        load0 = 1'b0;

        // asynchronous reset between edges while counting
        ce0 = 1'b0; load0 = 1'b1; d0 = 4'd7;
        edge_u0();
        load0 = 1'b0; ce0 = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(q0), 32'd0);
        check("arst_done", 32'(done0), 32'd0);
        check("arst_ovf", 32'(ovf0), 32'd0);
        check("arst_tc", 32'(tc0), 32'd0);
        mq = 0; mov = 1'b0;
        #1;
        rst = 1'b0;
        edge_only();

        // randomized traffic against the model
        for (int i = 0; i < 150; i++) begin
            ce0   = 1'($urandom_range(0, 1));
            up0   = 1'($urandom_range(0, 1));
            load0 = ($urandom_range(0, 7) == 0);
            d0    = 4'($urandom_range(0, 15));
            edge_u0();
        end
        ce0 = 1'b0; load0 = 1'b0;

        // one-shot: stop at 9, then reload and resume
        ce1 = 1'b1; up1 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("os_q", 32'(q1), 32'(k));
            check("os_done", 32'(done1), 32'd0);
        end
        check("os_rc_pre", 32'(rc1), 32'd1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("os_q_halt", 32'(q1), 32'd9);
            check("os_done_halt", 32'(done1), 32'd1);
            check("os_rc_halt", 32'(rc1), 32'd0);
            check("os_tc_halt", 32'(tc1), 32'd1);
        end
        load1 = 1'b1; d1 = 4'd2;
        @(posedge clk); #1;
        check("os_q_load", 32'(q1), 32'd2);
        check("os_done_load", 32'(done1), 32'd0);
        check("os_ovf_load", 32'(ovf1), 32'd0);
        load1 = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            @(posedge clk); #1;
            check("os_q_resume", 32'(q1), 32'(k));
        end
        ce1 = 1'b0;

        // two-stage decade cascade 0..99 and back to 00
        cce = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            check("casc_lo", 32'(qlo), 32'(n % 10));
            check("casc_hi", 32'(qhi), 32'((n / 10) % 10));
            check("casc_tclo", 32'(tclo), 32'((n % 10) == 9));
            check("casc_tchi", 32'(tchi), 32'(((n / 10) % 10) == 9));
            check("casc_rchi", 32'(rchi), 32'((n % 100) == 99));
        end
        cce = 1'b0;
        #1;
        check("casc_ovflo", 32'(ovflo), 32'(exp_ovf(1'b1)));
        check("casc_ovfhi", 32'(ovfhi), 32'(exp_ovf(1'b1)));
        check("casc_done", 32'({donehi, donelo}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
